// File: rtl/key_entry.sv
// key_entry: debounces raw keypad codes and turns accepted keys into digit write strobes,
// operand-select toggles (enter) and clear pulses. Outputs are registered.
// Optional macro KEY_ENTRY_DEBOUNCE_EN: defined = DB_CYCLES-sample debounce, undefined = single-sample accept.

`ifndef KEY_NONE
`define KEY_0    5'd0
`define KEY_1    5'd1
`define KEY_2    5'd2
`define KEY_3    5'd3
`define KEY_4    5'd4
`define KEY_5    5'd5
`define KEY_6    5'd6
`define KEY_7    5'd7
`define KEY_8    5'd8
`define KEY_9    5'd9
`define KEY_ENT  5'd10
`define KEY_CLR  5'd11
`define KEY_NONE 5'd31
`define SL_A     3'b001
`define SL_B     3'b010
`endif

module key_entry #(
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_raw,
  output logic [4:0] key,
  output logic [1:0] index,
  output logic       enabled,
  output logic [2:0] ST_L,
  output logic       clr
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, HELD} state_t;

  state_t     state, state_nx;
  logic [4:0] key_q;
  logic [4:0] cand, cand_nx;
  logic       stab_done;   // candidate has been seen stable long enough
  logic       rel_done;    // key has been released long enough to re-arm

  logic [4:0] key_nx;
  logic [1:0] index_nx;
  logic       enabled_nx;
  logic       clr_nx;
  logic [2:0] st_l_nx;

  // Single synchronising stage; all decisions use key_q only
  always_ff @(posedge clk) begin
    if (rst) key_q <= `KEY_NONE;
    else     key_q <= key_raw;
  end

`ifdef KEY_ENTRY_DEBOUNCE_EN
  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX   = CW'(DB_CYCLES);
  localparam logic [CW-1:0] REL_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] stab_cnt, stab_nx;
  logic [CW-1:0] rel_cnt, rel_nx;

  assign stab_done = (stab_cnt >= DB_MAX);
  assign rel_done  = (key_q == `KEY_NONE) && (rel_cnt >= REL_LAST);

  // Stability and release counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt <= '0;
      rel_cnt  <= '0;
    end else begin
      stab_cnt <= stab_nx;
      rel_cnt  <= rel_nx;
    end
  end

  // Counter next values: load on new candidate, saturate at DB_CYCLES, clear otherwise
  always_comb begin
    stab_nx = '0;
    rel_nx  = '0;
    case (state)
      IDLE: begin
        if (key_q != `KEY_NONE) stab_nx = CW'(1);
      end
      DEBOUNCE: begin
        if (!stab_done) begin
          if (key_q == cand)
            stab_nx = (stab_cnt >= DB_MAX) ? stab_cnt : stab_cnt + CW'(1);
          else if (key_q != `KEY_NONE)
            stab_nx = CW'(1);
        end
      end
      HELD: begin
        if (key_q == `KEY_NONE && !rel_done)
          rel_nx = (rel_cnt >= DB_MAX) ? rel_cnt : rel_cnt + CW'(1);
      end
      default: ;
    endcase
  end
`else
  // Without debouncing the first sample is enough in both directions
  assign stab_done = 1'b1;
  assign rel_done  = (key_q == `KEY_NONE);
`endif

  // State and candidate registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cand  <= `KEY_NONE;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
    end
  end

  // Next-state logic; a changed non-NONE code restarts debouncing with the new candidate
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    case (state)
      IDLE: begin
        if (key_q != `KEY_NONE) begin
          state_nx = DEBOUNCE;
          cand_nx  = key_q;
        end
      end
      DEBOUNCE: begin
        if (stab_done)                 state_nx = ACCEPT;
        else if (key_q == `KEY_NONE)   state_nx = IDLE;
        else if (key_q != cand)        cand_nx  = key_q;
      end
      ACCEPT:  state_nx = HELD;
      HELD: begin
        if (rel_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output next values: act on the candidate while in ACCEPT; position advances after the strobe
  always_comb begin
    key_nx     = key;
    index_nx   = enabled ? index + 2'd1 : index;
    enabled_nx = 1'b0;
    clr_nx     = 1'b0;
    st_l_nx    = ST_L;
    if (state == ACCEPT) begin
      if (cand <= `KEY_9) begin
        enabled_nx = 1'b1;
        key_nx     = cand;
      end else if (cand == `KEY_ENT) begin
        st_l_nx  = (ST_L == `SL_A) ? `SL_B : `SL_A;
        index_nx = 2'd0;
      end else if (cand == `KEY_CLR) begin
        clr_nx   = 1'b1;
        index_nx = 2'd0;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      key     <= `KEY_NONE;
      index   <= 2'd0;
      enabled <= 1'b0;
      clr     <= 1'b0;
      ST_L    <= `SL_A;
    end else begin
      key     <= key_nx;
      index   <= index_nx;
      enabled <= enabled_nx;
      clr     <= clr_nx;
      ST_L    <= st_l_nx;
    end
  end

endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry: directed key sequences, expected strobes/clears queued and checked by a monitor.
module tb_key_entry;

  localparam int DB = 4;
`ifdef KEY_ENTRY_DEBOUNCE_EN
  localparam int EFF = DB;
`else
  localparam int EFF = 1;
`endif

  localparam logic [4:0] K_NONE = 5'd31;
  localparam logic [4:0] K_ENT  = 5'd10;
  localparam logic [4:0] K_CLR  = 5'd11;
  localparam logic [2:0] SLA    = 3'b001;
  localparam logic [2:0] SLB    = 3'b010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] key_raw = 5'd31;
  logic [4:0] key;
  logic [1:0] index;
  logic       enabled;
  logic [2:0] ST_L;
  logic       clr;

  key_entry #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .key(key), .index(index), .enabled(enabled), .ST_L(ST_L), .clr(clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_clr;
    logic [4:0] k;
    logic [1:0] idx;
    logic [2:0] sl;
    int         at;
  } exp_t;

  exp_t       sbq[$];
  exp_t       e;
  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] m_pos = 2'd0;
  logic [2:0] m_sl  = 3'b001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe or clear must match the head of the expectation queue
  always @(negedge clk) begin
    if (enabled === 1'b1 || clr === 1'b1) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: enabled=%b clr=%b key=%0d index=%0d at cycle %0d, expected none",
                 enabled, clr, key, index, cyc);
      end else begin
        e = sbq.pop_front();
        chk("event_kind", {30'd0, enabled, clr}, e.is_clr ? 32'd1 : 32'd2);
        chk("event_cycle", cyc, e.at);
        if (!e.is_clr) begin
          chk("strobe_key", {27'd0, key}, {27'd0, e.k});
          chk("strobe_index", {30'd0, index}, {30'd0, e.idx});
        end else begin
          chk("clr_st_l", {29'd0, ST_L}, {29'd0, e.sl});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model of an accepted key whose first sample edge is c0+1
  task automatic expect_accept(input logic [4:0] code, input int c0);
    exp_t x;
    x.at = c0 + EFF + 3;
    x.sl = m_sl;
    x.k  = code;
    if (code <= 5'd9) begin
      x.is_clr = 1'b0;
      x.idx    = m_pos;
      sbq.push_back(x);
      m_pos = m_pos + 2'd1;
    end else if (code == K_ENT) begin
      m_sl  = (m_sl == SLA) ? SLB : SLA;
      m_pos = 2'd0;
    end else if (code == K_CLR) begin
      x.is_clr = 1'b1;
      x.idx    = 2'd0;
      sbq.push_back(x);
      m_pos = 2'd0;
    end
  endtask

  task automatic press(input logic [4:0] code, input int hold, input int rel);
    key_raw = code;
    expect_accept(code, cyc);
    tick(hold);
    key_raw = K_NONE;
    tick(rel);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    key_raw = K_NONE;
    tick(n);
    rst = 1'b0;
    m_pos = 2'd0;
    m_sl  = SLA;
    tick(2);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_key"}, {27'd0, key}, {27'd0, K_NONE});
    chk({tag, "_index"}, {30'd0, index}, 32'd0);
    chk({tag, "_enabled"}, {31'd0, enabled}, 32'd0);
    chk({tag, "_clr"}, {31'd0, clr}, 32'd0);
    chk({tag, "_st_l"}, {29'd0, ST_L}, {29'd0, SLA});
  endtask

  initial begin
    tick(3);
    chk_reset_values("reset");
    rst = 1'b0;
    tick(2);

    // Held digit: one strobe, index then 1
    press(5'd3, 10, 8);
    chk("idx_after_3", {30'd0, index}, 32'd1);

    // Bounce then steady 5
    for (int i = 0; i < 3; i++) begin
      key_raw = 5'd5;
      if (EFF == 1) expect_accept(5'd5, cyc);
      tick(2);
      key_raw = K_NONE;
      tick(2);
    end
    press(5'd5, 10, 8);
    chk("idx_after_bounce", {30'd0, index}, {30'd0, m_pos});

    // Wrap-around of digit position
    do_reset(2);
    for (int d = 1; d <= 5; d++) press(5'(d), 10, 8);
    chk("idx_after_wrap", {30'd0, index}, 32'd1);

    // Enter toggles operand select and clears position
    do_reset(2);
    press(5'd7, 10, 8);
    chk("idx_after_7", {30'd0, index}, 32'd1);
    press(K_ENT, 10, 8);
    chk("ent1_st_l", {29'd0, ST_L}, {29'd0, SLB});
    chk("ent1_index", {30'd0, index}, 32'd0);
    press(K_ENT, 10, 8);
    chk("ent2_st_l", {29'd0, ST_L}, {29'd0, SLA});

    // Clear after two digits keeps operand select
    press(K_ENT, 10, 8);
    press(5'd1, 10, 8);
    press(5'd2, 10, 8);
    chk("idx_before_clr", {30'd0, index}, 32'd2);
    press(K_CLR, 10, 8);
    chk("clr_index", {30'd0, index}, 32'd0);
    chk("clr_st_l_kept", {29'd0, ST_L}, {29'd0, SLB});

    // Reset mid-debounce aborts; key still held afterwards is a new press
    key_raw = 5'd9;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk_reset_values("midrst");
    rst = 1'b0;
    m_pos = 2'd0;
    m_sl  = SLA;
    expect_accept(5'd9, cyc);
    tick(10);
    key_raw = K_NONE;
    tick(8);
    chk("idx_after_rearm", {30'd0, index}, 32'd1);

    // Single-cycle glitch: accepted only without debouncing
    key_raw = 5'd6;
    if (EFF == 1) expect_accept(5'd6, cyc);
    tick(1);
    key_raw = K_NONE;
    tick(10);
    chk("idx_after_glitch", {30'd0, index}, {30'd0, m_pos});

    // Non-key code is ignored
    press(5'd20, 10, 8);
    chk("ignored_index", {30'd0, index}, {30'd0, m_pos});
    chk("ignored_st_l", {29'd0, ST_L}, {29'd0, SLA});

    tick(20);
    chk("queue_drained", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 Parameter DB_CYCLES, default 16, sets the number of consecutive stable samples needed to accept a key press or release.
REQ-002 clk  input  1  system clock; every register updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 key_raw  input  5  raw key code from the keypad decoder: `KEY_0..`KEY_9 are digits, `KEY_ENT is enter, `KEY_CLR is clear, `KEY_NONE means no key.
REQ-005 key  output  5  registered digit code presented to the Numerator.
REQ-006 index  output  2  digit position 0..3 that the current digit is written to.
REQ-007 enabled  output  1  one-cycle write strobe for key and index.
REQ-008 ST_L  output  3  operand select, either `SL_A or `SL_B.
REQ-009 clr  output  1  one-cycle pulse when a clear key is accepted.

Function
REQ-010 key_raw SHALL pass through one sync register, key_q, before any decision is made on it.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, ACCEPT and HELD.
REQ-012 IDLE -> DEBOUNCE on key_q != `KEY_NONE; the stability counter loads 1 and the candidate code is latched.
REQ-013 In DEBOUNCE, a key_q equal to the candidate SHALL increment the counter.
- If key_q differs but is not NONE, it becomes the new candidate and the counter reloads to 1.
- If key_q is NONE, the FSM returns to IDLE.
REQ-014 DEBOUNCE -> ACCEPT when the counter reaches DB_CYCLES; ACCEPT lasts exactly one cycle, then the FSM goes to HELD.
REQ-015 ACCEPT with a digit candidate SHALL, in the same cycle:
- drive enabled=1, key=candidate, index=current position;
- on the next edge, advance the position by 1 modulo 4, so 3 wraps to 0.
REQ-016 ACCEPT with `KEY_ENT SHALL toggle ST_L (`SL_A <-> `SL_B) and set the position to 0, with no enabled pulse.
REQ-017 ACCEPT with `KEY_CLR SHALL pulse clr=1 for one cycle and set the position to 0, with ST_L unchanged and no enabled pulse.
REQ-018 ACCEPT with any other non-NONE code SHALL be ignored: no output change, and the FSM still goes to HELD.
REQ-019 HELD SHALL return to IDLE only after key_q == `KEY_NONE for DB_CYCLES consecutive cycles; any non-NONE sample reloads the release counter to 0.
REQ-020 A held key SHALL produce exactly one accept, with no auto-repeat.
REQ-021 Latency: enabled asserts on the clock edge DB_CYCLES+2 edges after the edge that first samples a stable digit on key_raw.
REQ-022 key SHALL hold its last accepted digit between strobes; enabled is 0 in every state except ACCEPT.
REQ-023 The stability and release counters SHALL be wide enough for DB_CYCLES and SHALL saturate, never wrap.

Reset
REQ-024 With rst=1 on a clock edge, the block SHALL set: state=IDLE, key=`KEY_NONE, index=0, enabled=0, clr=0, ST_L=`SL_A, all counters=0, key_q=`KEY_NONE.
REQ-025 rst SHALL take priority over every other event; asserting it in DEBOUNCE, ACCEPT or HELD aborts the press without emitting a strobe.
REQ-026 After rst deasserts, a key already held down SHALL be accepted as a new press.

Configuration
REQ-027 Macro KEY_ENTRY_DEBOUNCE_EN controls debouncing.
- Defined: behaviour as in REQ-012..REQ-023.
- Undefined: the effective DB_CYCLES is 1, so a press is accepted on the first non-NONE key_q sample and a release on the first NONE sample; latency becomes 3 edges.
- Undefined: the counters are not instantiated.

Verification
REQ-028 DB_CYCLES=4, debounce enabled; hold `KEY_3 for 10 cycles, then NONE -> exactly one enabled pulse with key=`KEY_3, index=0, arriving 6 edges after the first sample; index becomes 1.
REQ-029 Bounce `KEY_5/NONE alternating every 2 cycles for 12 cycles, then `KEY_5 steady -> no strobe during the bounce, exactly one strobe after 4 stable samples.
REQ-030 Accept digits 1,2,3,4,5 in sequence -> strobes carry index 0,1,2,3,0 (wrap-around).
REQ-031 Accept `KEY_7 (index becomes 1), then `KEY_ENT -> ST_L=`SL_B, index=0, no strobe; a second `KEY_ENT -> ST_L=`SL_A.
REQ-032 Accept `KEY_CLR after two digits -> clr high for 1 cycle, index=0, ST_L unchanged; assert rst mid-DEBOUNCE -> no strobe, and all outputs take their REQ-024 values.
REQ-033 Repeat REQ-028 with KEY_ENTRY_DEBOUNCE_EN undefined -> strobe 3 edges after the first sample, and a single-cycle glitch is accepted as a press.
